// File: rtl/sram_wb_bridge.sv
// Wishbone B4 slave to synchronous SRAM bridge.
// Single writes and classic reads take two cycles; incrementing reads run as pipelined bursts.
module sram_wb_bridge #(
    parameter  int unsigned AW            = 32,
    parameter  int unsigned DW            = 32,
    localparam int unsigned SW            = DW / 8,
    parameter  int unsigned WORD_AW       = AW - (SW >> 1),
    parameter  int unsigned MEM_SIZE_BYTE = 32768
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [AW-1:0]      wb_adr_i,
    input  logic [DW-1:0]      wb_dat_i,
    input  logic [SW-1:0]      wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic [2:0]         wb_cti_i,
    input  logic [1:0]         wb_bte_i,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    output logic [DW-1:0]      wb_dat_o,
    output logic               sram_ce,
    output logic               sram_we,
    output logic               sram_oe,
    output logic [WORD_AW-1:0] sram_waddr,
    output logic [DW-1:0]      sram_din,
    output logic [SW-1:0]      sram_sel,
    input  logic [DW-1:0]      sram_dout
);

    // log2(SW) for the legal widths 1, 2 and 4 bytes
    localparam int unsigned OFF       = SW >> 1;
    localparam int unsigned MEM_WORDS = MEM_SIZE_BYTE / SW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WACK,
        S_RDWAIT,
        S_BURST,
        S_ERR
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WORD_AW-1:0]   r_ba;
    logic [WORD_AW-1:0]   w_ba_d;
    logic [WORD_AW-1:0]   w_ba_nxt;
    logic [WORD_AW-1:0]   w_ba_inc;
    logic [WORD_AW-1:0]   w_wrap_mask;
    logic [WORD_AW-1:0]   w_wadr;
    logic                 w_req;
    logic                 w_adr_oor;
    logic                 w_ba_oor;

    assign w_req     = wb_cyc_i & wb_stb_i;
    assign w_wadr    = WORD_AW'(wb_adr_i >> OFF);
    assign w_adr_oor = ({1'b0, wb_adr_i} >= (AW+1)'(MEM_SIZE_BYTE));
    assign w_ba_oor  = ({1'b0, r_ba} >= (WORD_AW+1)'(MEM_WORDS));
    assign wb_dat_o  = sram_dout;

    // Burst address advance: wrapping bursts only change the bits under the mask
    always_comb begin
        w_wrap_mask = '1;
        case (wb_bte_i)
            2'b01:   w_wrap_mask = WORD_AW'(3);
            2'b10:   w_wrap_mask = WORD_AW'(7);
            2'b11:   w_wrap_mask = WORD_AW'(15);
            default: w_wrap_mask = '1;
        endcase
        w_ba_inc = r_ba + WORD_AW'(1);
        w_ba_nxt = (r_ba & ~w_wrap_mask) | (w_ba_inc & w_wrap_mask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ba    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ba    <= w_ba_d;
        end
    end

    // Next state and SRAM/Wishbone strobes; SRAM commands must appear in the request cycle
    always_comb begin
        w_state_nxt = r_state;
        w_ba_d      = r_ba;
        sram_ce     = 1'b0;
        sram_we     = 1'b0;
        sram_oe     = 1'b0;
        sram_waddr  = w_wadr;
        sram_din    = wb_dat_i;
        sram_sel    = '0;
        wb_ack_o    = 1'b0;
        wb_err_o    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_adr_oor) begin
                        w_state_nxt = S_ERR;
                    end else if (wb_we_i) begin
                        sram_ce     = 1'b1;
                        sram_we     = 1'b1;
                        sram_sel    = wb_sel_i;
                        w_state_nxt = S_WACK;
                    end else begin
                        sram_ce  = 1'b1;
                        sram_oe  = 1'b1;
                        sram_sel = '1;
                        if (wb_cti_i == 3'b010) begin
                            w_ba_d      = w_wadr;
                            w_state_nxt = S_BURST;
                        end else begin
                            w_state_nxt = S_RDWAIT;
                        end
                    end
                end
            end

            S_WACK, S_RDWAIT: begin
                wb_ack_o    = w_req;
                w_state_nxt = S_IDLE;
            end

            S_ERR: begin
                wb_err_o    = w_req;
                w_state_nxt = S_IDLE;
            end

            S_BURST: begin
                if (!wb_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else if (!wb_stb_i) begin
                    // master wait state: keep the current beat's data on sram_dout
                    sram_ce    = 1'b1;
                    sram_oe    = 1'b1;
                    sram_sel   = '1;
                    sram_waddr = r_ba;
                end else if (w_ba_oor) begin
                    wb_err_o    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    wb_ack_o   = 1'b1;
                    sram_ce    = 1'b1;
                    sram_oe    = 1'b1;
                    sram_sel   = '1;
                    sram_waddr = w_ba_nxt;
                    w_ba_d     = w_ba_nxt;
                    if (wb_cti_i != 3'b010) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase

        if (rst) begin
            sram_ce  = 1'b0;
            sram_we  = 1'b0;
            sram_oe  = 1'b0;
            sram_sel = '0;
            wb_ack_o = 1'b0;
            wb_err_o = 1'b0;
        end
    end

endmodule

// File: doc/sram_wb_bridge.md
SRAM_WB_BRIDGE -- requirements
Module: sram_wb_bridge

Interface
REQ-001: The block SHALL have parameter AW, default 32, meaning the Wishbone byte address width.
REQ-002: The block SHALL have parameter DW, default 32, meaning the data width; legal values are 8, 16 and 32.
REQ-003: The block SHALL derive localparam SW = DW/8 (byte selects) and parameter WORD_AW = AW - (SW>>1), meaning the SRAM word address width.
REQ-004: The block SHALL have parameter MEM_SIZE_BYTE, default 32768, meaning the attached SRAM size in bytes.
REQ-005: The block SHALL have one clock; reset is asynchronous and active-high; ports: clk in 1 clock; rst in 1 reset.
REQ-006: The block SHALL have Wishbone slave inputs: wb_adr_i AW, wb_dat_i DW, wb_sel_i SW, wb_we_i 1, wb_cyc_i 1, wb_stb_i 1, wb_cti_i 3, wb_bte_i 2.
REQ-007: The block SHALL have Wishbone slave outputs: wb_ack_o 1, wb_err_o 1, wb_dat_o DW.
REQ-008: The block SHALL have SRAM initiator outputs: sram_ce 1, sram_we 1, sram_oe 1, sram_waddr WORD_AW, sram_din DW, sram_sel SW.
REQ-009: The block SHALL have SRAM initiator input sram_dout DW, the registered read data valid one cycle after the address is presented.

Function
REQ-010: The block SHALL implement FSM states IDLE, WACK, RDWAIT, BURST and ERR.
REQ-011: The word address SHALL be wb_adr_i[AW-1:log2(SW)]; byte offset bits SHALL be ignored.
REQ-012: An access SHALL be out of range when wb_adr_i >= MEM_SIZE_BYTE.
REQ-013: IDLE, cyc&stb, out of range -> ERR; no SRAM signal SHALL be asserted.
REQ-014: IDLE, cyc&stb&we, in range -> the block SHALL drive sram_ce=sram_we=1, sram_din=wb_dat_i and sram_sel=wb_sel_i in the same cycle, then go to WACK.
REQ-015: IDLE, cyc&stb&~we, in range -> the block SHALL drive sram_ce=sram_oe=1 and sram_sel all ones; next state SHALL be BURST if cti=010, else RDWAIT.
REQ-016: wb_ack_o SHALL equal cyc&stb in WACK, RDWAIT and BURST, and SHALL be 0 otherwise; wb_err_o SHALL equal cyc&stb in ERR (and on out-of-range BURST beats), and SHALL be 0 otherwise.
REQ-017: wb_dat_o SHALL equal sram_dout.
REQ-018: WACK, RDWAIT and ERR SHALL return to IDLE after one cycle; every write and every classic read SHALL take 2 cycles per beat.
REQ-019: BURST SHALL keep a beat address register ba, the word whose data is on sram_dout.
REQ-019a: While ack: the block SHALL present next(ba) with ce=oe=1 and load ba<=next(ba).
REQ-019b: While stb=0 inside cyc: the block SHALL re-present ba with no ack, so the data stays valid.
REQ-020: next(ba) SHALL be: bte=00 -> ba+1; bte=01/10/11 -> increment modulo 4/8/16 words within the aligned block, upper bits unchanged.
REQ-021: BURST SHALL return to IDLE after acking a beat with cti=111, or after any beat with cti not equal to 010.
REQ-022: If ba is out of range in BURST, the block SHALL assert err instead of ack for that beat and go to IDLE.
REQ-023: cyc deasserted in any non-IDLE state -> IDLE next cycle, with no ack and no err.
REQ-024: Writes SHALL never be issued in BURST; a burst write (we with cti=010) SHALL be served as sequential 2-cycle single writes.
REQ-025: sram_we SHALL be asserted only in IDLE, so one beat produces exactly one write.

Reset
REQ-026: On rst high (async), the FSM SHALL go to IDLE, ba SHALL be 0, and all SRAM outputs and wb_ack_o/wb_err_o SHALL be 0 immediately.
REQ-027: Reset mid-burst or mid-write SHALL abort with no ack; after rst falls, the block SHALL accept a new cycle in the first clock.

Verification
REQ-028: Write adr=0x10, dat=0xDEADBEEF, sel=0xF -> sram_we=1, waddr=4 in cycle 0; ack in cycle 1; a read of 0x10 then returns 0xDEADBEEF with ack in cycle 1.
REQ-029: Write sel=0x2, dat=0x0000AA00 over 0x11223344 at adr 0x20 -> readback 0x1122AA44.
REQ-030: Linear burst read of 4 beats from 0x100 (cti 010,010,010,111) -> acks on 4 consecutive cycles after 1 wait cycle, waddr 0x40..0x43.
REQ-031: Wrap-4 burst from adr 0x108 -> beat word addresses 0x42, 0x43, 0x40, 0x41; stb low for 2 cycles mid-burst -> no ack and correct data on resume.
REQ-032: Read adr=MEM_SIZE_BYTE -> err in cycle 1, no ack, sram_ce=0 throughout; linear burst starting at the last word -> 1 ack then err.
REQ-033: rst asserted during BURST beat 2 -> ack and ce drop in the same cycle; a subsequent single read succeeds.
